// File: rtl/input_logic_pkg.sv
// Shared types and constants for the four-button input front end.
package input_logic_pkg;

    // Per-button hold/auto-repeat state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_e;

    // Button positions on the BTN/LEVEL/PRESS/RELEASE vectors.
    localparam int unsigned BTN_START = 0;
    localparam int unsigned BTN_CLEAR = 1;
    localparam int unsigned BTN_UP    = 2;
    localparam int unsigned BTN_DOWN  = 3;
    localparam int unsigned NUM_BTN   = BTN_DOWN + 1;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: two-flop synchronizer followed by a saturating
// stability counter. LEVEL flips after DEBOUNCE_CYCLES consecutive synced
// samples that disagree with it; RISE/FALL pulse in the same cycle.
module button_debounce
    import input_logic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic RAW,
    output logic LEVEL,
    output logic RISE,
    output logic FALL
);

    localparam int unsigned   CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LIM = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Synchronizer shift and debounce decision for the next cycle.
    always_comb begin
        sync_d  = {sync_q[0], RAW};
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        cnt_d   = cnt_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LIM) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
                fall_d  = level_q;
                cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign LEVEL = level_q;
    assign RISE  = rise_q;
    assign FALL  = fall_q;

endmodule

// File: rtl/input_logic.sv
// Four-button front end: debounced levels, press/release pulses and an
// optional per-button auto-repeat.
// Build option: define INPUT_LOGIC_AUTOREPEAT_EN to compile in auto-repeat;
// without it every accepted press gives exactly one PRESS pulse.
module input_logic
    import input_logic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter logic [3:0]  REPEAT_MASK     = 4'b1100
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] BTN,
    output logic [3:0] LEVEL,
    output logic [3:0] PRESS,
    output logic [3:0] RELEASE
);

    logic [NUM_BTN-1:0] level_s;
    logic [NUM_BTN-1:0] rise_s;
    logic [NUM_BTN-1:0] fall_s;

    btn_state_e state_q [NUM_BTN];
    btn_state_e state_d [NUM_BTN];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .CLK  (CLK),
            .RST  (RST),
            .RAW  (BTN[i]),
            .LEVEL(level_s[i]),
            .RISE (rise_s[i]),
            .FALL (fall_s[i])
        );
    end

`ifdef INPUT_LOGIC_AUTOREPEAT_EN
    // One counter per button serves both the initial delay and the period.
    localparam int unsigned   RPT_SPAN   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned   RW         = cnt_width(RPT_SPAN);
    localparam logic [RW-1:0] DELAY_LIM  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LIM = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] RPT_MAX    = {RW{1'b1}};

    logic [RW-1:0]      rpt_cnt_q [NUM_BTN];
    logic [RW-1:0]      rpt_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] rpt_pulse_q, rpt_pulse_d;

    // Hold/repeat FSM per button; the repeat pulse is decided one cycle
    // ahead so it can come straight from a flop in the cycle it is due.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i]   = state_q[i];
            rpt_cnt_d[i] = rpt_cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (rise_s[i]) begin
                        state_d[i]   = HELD;
                        rpt_cnt_d[i] = '0;
                    end else begin
                        state_d[i]   = IDLE;
                    end
                end
                HELD: begin
                    if (fall_s[i]) begin
                        state_d[i]   = IDLE;
                        rpt_cnt_d[i] = '0;
                    end else if (REPEAT_MASK[i] && (rpt_cnt_q[i] == DELAY_LIM)) begin
                        state_d[i]   = REPEAT;
                        rpt_cnt_d[i] = '0;
                    end else if (rpt_cnt_q[i] == RPT_MAX) begin
                        rpt_cnt_d[i] = rpt_cnt_q[i];
                    end else begin
                        rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
                    end
                end
                REPEAT: begin
                    if (fall_s[i]) begin
                        state_d[i]   = IDLE;
                        rpt_cnt_d[i] = '0;
                    end else if (rpt_cnt_q[i] == PERIOD_LIM) begin
                        rpt_cnt_d[i] = '0;
                    end else if (rpt_cnt_q[i] == RPT_MAX) begin
                        rpt_cnt_d[i] = rpt_cnt_q[i];
                    end else begin
                        rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
                    end
                end
                default: begin
                    state_d[i]   = IDLE;
                    rpt_cnt_d[i] = '0;
                end
            endcase
            rpt_pulse_d[i] = ((state_d[i] == HELD) && REPEAT_MASK[i] && (rpt_cnt_d[i] == DELAY_LIM))
                           || ((state_d[i] == REPEAT) && (rpt_cnt_d[i] == PERIOD_LIM));
        end
    end

    // FSM, repeat counter and repeat-pulse registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i]   <= IDLE;
                rpt_cnt_q[i] <= '0;
            end
            rpt_pulse_q <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i]   <= state_d[i];
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
            rpt_pulse_q <= rpt_pulse_d;
        end
    end

    // A repeat that coincides with the release cycle is dropped: LEVEL is
    // already low then.
    assign PRESS = rise_s | (rpt_pulse_q & level_s);
`else
    // Repeat timing has no effect in this build; the parameters are kept so
    // both builds share one interface.
    if ((REPEAT_DELAY == 0) || (REPEAT_PERIOD == 0) || (REPEAT_MASK == 4'b0000)) begin : g_repeat_params_ignored
    end

    // Hold tracking per button without repeat.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE: begin
                    if (rise_s[i]) begin
                        state_d[i] = HELD;
                    end else begin
                        state_d[i] = IDLE;
                    end
                end
                HELD: begin
                    if (fall_s[i]) begin
                        state_d[i] = IDLE;
                    end else begin
                        state_d[i] = HELD;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    assign PRESS = rise_s;
`endif

    assign LEVEL   = level_s;
    assign RELEASE = fall_s;

endmodule
